hack_screen_fetch: RTL and testbench

//  Pixel stage downstream of VGA_SYNC. Consumes pixel_row/pixel_column/video_on/syncs,

---
 rtl/hack_screen_fetch.sv | 205 ++++++++++++++++++++
 tb/tb_hack_screen_fetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_screen_fetch.sv
// ---------------------------------------------------------------------------
// hack_screen_fetch
//
// Pixel stage that sits behind VGA_SYNC. It places the 512x256 Hack screen
// inside the 640x480 active area, fetches one 16-bit screen word per 16
// pixels from the screen RAM, and shifts each word out LSB-first as mono
// pixels. It produces registered 12-bit RGB, and delays the syncs and video_on
// by the same single cycle so they stay aligned with the colour.
//
// Parameters
//   H_OFFSET     first window column (multiple of 16, >= 16)
//   V_OFFSET     first window row (window rows V_OFFSET..V_OFFSET+255)
//   RAM_LATENCY  cycles from mem_rd to valid mem_rdata (1..15)
//   FG_RGB       colour for a screen bit of 1
//   BG_RGB       colour for a screen bit of 0
//   BORDER_RGB   colour inside video_on but outside the window
//
// Ports
//   pixel_clock     in   single clock, rising edge
//   reset           in   synchronous, active-high
//   pixel_row       in   [9:0] current row from VGA_SYNC
//   pixel_column    in   [9:0] current column from VGA_SYNC
//   video_on        in   active-area flag
//   horiz_sync_in   in   hsync (active low)
//   vert_sync_in    in   vsync (active low)
//   mem_addr        out  [12:0] screen word address = (row-V_OFFSET)*32 + k
//   mem_rd          out  one-cycle read strobe
//   mem_rdata       in   [15:0] screen RAM data, valid RAM_LATENCY cycles
//                        after the cycle in which mem_rd is high
//   rgb             out  [11:0] {R,G,B}
//   horiz_sync_out  out  hsync delayed one cycle
//   vert_sync_out   out  vsync delayed one cycle
//   video_on_out    out  video_on delayed one cycle
//
// Optional feature (macro SCREEN_FRAME_TICK_EN)
//   frame_tick      out  one-cycle pulse the cycle after vert_sync_in falls
//   frame_count     out  [15:0] count of frame_tick pulses, wraps
//
// Read protocol: mem_rd is a fire-and-forget strobe. There is no ready or
// backpressure; the RAM must return data exactly RAM_LATENCY cycles later.
// A shift pipe of the strobe marks the cycle in which mem_rdata is valid.
// ---------------------------------------------------------------------------
module hack_screen_fetch #(
  parameter int          H_OFFSET    = 64,
  parameter int          V_OFFSET    = 112,
  parameter int          RAM_LATENCY = 1,
  parameter logic [11:0] FG_RGB      = 12'h000,
  parameter logic [11:0] BG_RGB      = 12'hFFF,
  parameter logic [11:0] BORDER_RGB  = 12'h444
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic [9:0]  pixel_row,
  input  logic [9:0]  pixel_column,
  input  logic        video_on,
  input  logic        horiz_sync_in,
  input  logic        vert_sync_in,
  output logic [12:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  output logic [11:0] rgb,
  output logic        horiz_sync_out,
  output logic        vert_sync_out,
  output logic        video_on_out
`ifdef SCREEN_FRAME_TICK_EN
  ,
  output logic        frame_tick,
  output logic [15:0] frame_count
`endif
);

  // Window and request column bounds. Word k is requested 16 columns
  // before it is displayed, so requests run from H_OFFSET-16 to H_OFFSET+480.
  localparam logic [9:0] WIN_COL_FIRST = 10'(H_OFFSET);
  localparam logic [9:0] WIN_COL_LAST  = 10'(H_OFFSET + 511);
  localparam logic [9:0] WIN_ROW_FIRST = 10'(V_OFFSET);
  localparam logic [9:0] WIN_ROW_LAST  = 10'(V_OFFSET + 255);
  localparam logic [9:0] REQ_COL_FIRST = 10'(H_OFFSET - 16);
  localparam logic [9:0] REQ_COL_LAST  = 10'(H_OFFSET + 480);

  // Registered state
  logic [11:0]            rgb_q,      rgb_d;
  logic                   hs_q;
  logic                   vs_q;
  logic                   von_q;
  logic                   mem_rd_q;
  logic [12:0]            mem_addr_q;
  logic [RAM_LATENCY-1:0] rv_q;
  logic [15:0]            hold_q,     hold_d;
  logic [15:0]            shift_q,    shift_d;

  // Combinational decode of the current input position
  logic        row_in_win;
  logic        col_in_win;
  logic        in_win;
  logic        word_start;
  logic        req_hit;
  logic [7:0]  row_rel;
  logic [4:0]  word_idx;
  logic        rd_valid;
  logic [15:0] load_word;
  logic        pix_bit;

  assign row_rel  = 8'(pixel_row - WIN_ROW_FIRST);
  assign word_idx = 5'((pixel_column - REQ_COL_FIRST) >> 4);
  assign rd_valid = rv_q[RAM_LATENCY-1];

  always_comb begin
    row_in_win = (pixel_row >= WIN_ROW_FIRST) && (pixel_row <= WIN_ROW_LAST);
    col_in_win = (pixel_column >= WIN_COL_FIRST) && (pixel_column <= WIN_COL_LAST);
    in_win     = row_in_win && col_in_win;
    // H_OFFSET is a multiple of 16, so word boundaries are where the low
    // four column bits are zero.
    word_start = in_win && (pixel_column[3:0] == 4'd0);
    req_hit    = row_in_win
               && (pixel_column >= REQ_COL_FIRST)
               && (pixel_column <= REQ_COL_LAST)
               && (pixel_column[3:0] == 4'd0);

    // Data arriving in the very cycle of a word boundary (RAM_LATENCY=15)
    // is forwarded straight into the shifter instead of via the hold reg.
    load_word = rd_valid ? mem_rdata : hold_q;
    hold_d    = load_word;

    shift_d = shift_q;
    pix_bit = shift_q[0];
    if (word_start) begin
      pix_bit = load_word[0];
      shift_d = {1'b0, load_word[15:1]};
    end else if (in_win) begin
      shift_d = {1'b0, shift_q[15:1]};
    end

    rgb_d = 12'h000;
    if (video_on) begin
      if (in_win) begin
        rgb_d = pix_bit ? FG_RGB : BG_RGB;
      end else begin
        rgb_d = BORDER_RGB;
      end
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      rgb_q      <= 12'h000;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      von_q      <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= 13'd0;
      rv_q       <= '0;
      hold_q     <= 16'h0000;
      shift_q    <= 16'h0000;
    end else begin
      rgb_q    <= rgb_d;
      hs_q     <= horiz_sync_in;
      vs_q     <= vert_sync_in;
      von_q    <= video_on;
      mem_rd_q <= req_hit;
      if (req_hit) begin
        mem_addr_q <= {row_rel, word_idx};
      end
      rv_q[0] <= mem_rd_q;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        rv_q[i] <= rv_q[i-1];
      end
      hold_q  <= hold_d;
      shift_q <= shift_d;
    end
  end

  assign rgb            = rgb_q;
  assign horiz_sync_out = hs_q;
  assign vert_sync_out  = vs_q;
  assign video_on_out   = von_q;
  assign mem_rd         = mem_rd_q;
  assign mem_addr       = mem_addr_q;

`ifdef SCREEN_FRAME_TICK_EN
  // vs_q already holds last cycle's vsync (and resets high), so a falling
  // edge is vs_q high with the current input low.
  logic        frame_tick_q;
  logic [15:0] frame_count_q;
  logic        vs_fall;

  assign vs_fall = vs_q & ~vert_sync_in;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      frame_tick_q  <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      frame_tick_q <= vs_fall;
      if (vs_fall) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign frame_tick  = frame_tick_q;
  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_hack_screen_fetch.sv
// ---------------------------------------------------------------------------
// Bench for hack_screen_fetch. Two instances share the pixel inputs: one with
// RAM_LATENCY=1 and one with RAM_LATENCY=3, each fed by its own RAM model over
// a common screen array. Every driven pixel pushes its expected outputs onto
// exp_q; the next step pops the entry and compares both instances.
// ---------------------------------------------------------------------------
module tb_hack_screen_fetch;

  localparam int W     = 32;
  localparam int H_OFF = 64;
  localparam int V_OFF = 112;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [9:0]  pixel_row;
  logic [9:0]  pixel_column;
  logic        video_on;
  logic        hs_in;
  logic        vs_in;

  logic [12:0] mem_addr_a, mem_addr_b;
  logic        mem_rd_a,   mem_rd_b;
  logic [15:0] mem_rdata_a, mem_rdata_b;
  logic [11:0] rgb_a, rgb_b;
  logic        hs_a, hs_b, vs_a, vs_b, von_a, von_b;
`ifdef SCREEN_FRAME_TICK_EN
  logic        tick_a, tick_b;
  logic [15:0] fc_a, fc_b;
`endif

  hack_screen_fetch #(.RAM_LATENCY(1)) dut_a (
    .pixel_clock    (clk),
    .reset          (reset),
    .pixel_row      (pixel_row),
    .pixel_column   (pixel_column),
    .video_on       (video_on),
    .horiz_sync_in  (hs_in),
    .vert_sync_in   (vs_in),
    .mem_addr       (mem_addr_a),
    .mem_rd         (mem_rd_a),
    .mem_rdata      (mem_rdata_a),
    .rgb            (rgb_a),
    .horiz_sync_out (hs_a),
    .vert_sync_out  (vs_a),
    .video_on_out   (von_a)
`ifdef SCREEN_FRAME_TICK_EN
    ,
    .frame_tick     (tick_a),
    .frame_count    (fc_a)
`endif
  );

  hack_screen_fetch #(.RAM_LATENCY(3)) dut_b (
    .pixel_clock    (clk),
    .reset          (reset),
    .pixel_row      (pixel_row),
    .pixel_column   (pixel_column),
    .video_on       (video_on),
    .horiz_sync_in  (hs_in),
    .vert_sync_in   (vs_in),
    .mem_addr       (mem_addr_b),
    .mem_rd         (mem_rd_b),
    .mem_rdata      (mem_rdata_b),
    .rgb            (rgb_b),
    .horiz_sync_out (hs_b),
    .vert_sync_out  (vs_b),
    .video_on_out   (von_b)
`ifdef SCREEN_FRAME_TICK_EN
    ,
    .frame_tick     (tick_b),
    .frame_count    (fc_b)
`endif
  );

  // ---------------- screen RAM models ----------------
  logic [15:0] ram [0:8191];
  logic [15:0] pa;
  logic [15:0] pb [0:2];

  always @(posedge clk) begin
    pa    <= ram[mem_addr_a];
    pb[0] <= ram[mem_addr_b];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign mem_rdata_a = pa;
  assign mem_rdata_b = pb[2];

  // ---------------- scoreboard ----------------
  // entry: [31] rgb_en [30:19] rgb [18:16] {hs,vs,von} [15] rd [14] addr_en
  //        [13:1] addr [0] frame_tick
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rd_seen_a = 0;
  int rd_seen_b = 0;
  int ticks_seen = 0;
  int blank_row = -1;
  int blank_end = 0;
  logic prev_vs_m = 1'b1;
  int fc_m = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input int row, input int col);
    logic [15:0] w;
    int a;
    if (!(row < 480 && col < 640)) return 12'h000;
    if (row >= V_OFF && row <= V_OFF + 255 && col >= H_OFF && col <= H_OFF + 511) begin
      if (row == blank_row && col < blank_end) return 12'hFFF;
      a = (row - V_OFF) * 32 + (col - H_OFF) / 16;
      w = ram[a];
      return w[(col - H_OFF) % 16] ? 12'h000 : 12'hFFF;
    end
    return 12'h444;
  endfunction

  task automatic check_out();
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sync_von_a", {29'd0, hs_a, vs_a, von_a}, {29'd0, e[18:16]});
      chk("sync_von_b", {29'd0, hs_b, vs_b, von_b}, {29'd0, e[18:16]});
      if (e[31]) begin
        chk("rgb_a", {20'd0, rgb_a}, {20'd0, e[30:19]});
        chk("rgb_b", {20'd0, rgb_b}, {20'd0, e[30:19]});
      end
      chk("mem_rd_a", {31'd0, mem_rd_a}, {31'd0, e[15]});
      chk("mem_rd_b", {31'd0, mem_rd_b}, {31'd0, e[15]});
      if (mem_rd_a) rd_seen_a++;
      if (mem_rd_b) rd_seen_b++;
      if (e[14]) begin
        chk("mem_addr_a", {19'd0, mem_addr_a}, {19'd0, e[13:1]});
        chk("mem_addr_b", {19'd0, mem_addr_b}, {19'd0, e[13:1]});
      end
`ifdef SCREEN_FRAME_TICK_EN
      chk("frame_tick_a", {31'd0, tick_a}, {31'd0, e[0]});
      chk("frame_tick_b", {31'd0, tick_b}, {31'd0, e[0]});
      if (tick_a) ticks_seen++;
`endif
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input int row, input int col, input logic rst, input logic vs);
    logic [W-1:0] e;
    logic von, hs, rd, tick;
    int addr;
    @(negedge clk);
    check_out();
    von = (row < 480) && (col < 640);
    hs  = !(col >= 656 && col <= 671);
    reset        = rst;
    pixel_row    = 10'(row);
    pixel_column = 10'(col);
    video_on     = von;
    hs_in        = hs;
    vs_in        = vs;
    if (rst) begin
      e = {1'b1, 12'h000, 3'b110, 1'b0, 1'b1, 13'd0, 1'b0};
      // The shifter and hold register are cleared, so window pixels stay
      // background until the boundary of the first word requested after reset.
      blank_row = row;
      blank_end = (col / 16 + 1) * 16 + 16;
      prev_vs_m = 1'b1;
      fc_m = 0;
    end else begin
      rd = (row >= V_OFF) && (row <= V_OFF + 255) && (col >= H_OFF - 16)
        && (col <= H_OFF + 480) && (col % 16 == 0);
      addr = (row - V_OFF) * 32 + (col - (H_OFF - 16)) / 16;
      tick = prev_vs_m && !vs;
      if (tick) fc_m++;
      prev_vs_m = vs;
      e = {1'b1, model_rgb(row, col), hs, vs, von, rd, rd, 13'(addr), tick};
    end
    exp_q.push_back(e);
  endtask

  task automatic scan_line(input int row, input int rst_col);
    int exp_rd;
    rd_seen_a = 0;
    rd_seen_b = 0;
    for (int c = 0; c < 680; c++) begin
      step(row, c, (c == rst_col), 1'b1);
    end
    exp_rd = (row >= V_OFF && row <= V_OFF + 255) ? 32 : 0;
    chk("rd_per_line_a", 32'(rd_seen_a), 32'(exp_rd));
    chk("rd_per_line_b", 32'(rd_seen_b), 32'(exp_rd));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset        = 1'b1;
    pixel_row    = 10'd0;
    pixel_column = 10'd0;
    video_on     = 1'b0;
    hs_in        = 1'b1;
    vs_in        = 1'b1;
    for (int i = 0; i < 8192; i++) ram[i] = 16'h0000;
    ram[0] = 16'h0001;                                        // row 112 word 0
    for (int k = 0; k < 32; k++) ram[1 * 32 + k]   = 16'($urandom);   // row 113
    for (int k = 0; k < 32; k++) ram[38 * 32 + k]  = 16'hFFFF;        // row 150
    for (int k = 0; k < 32; k++) ram[254 * 32 + k] = 16'($urandom);   // row 366
    for (int k = 0; k < 31; k++) ram[255 * 32 + k] = 16'($urandom);   // row 367
    ram[8191] = 16'h8000;

    // Reset values
    for (int i = 0; i < 3; i++) step(0, 0, 1'b1, 1'b1);

    // Lines straddling the top of the window, including word 0 and the edges
    scan_line(111, -1);
    scan_line(112, -1);
    scan_line(113, -1);

    // Reset pulse mid-line at column 200
    scan_line(150, 200);
    blank_row = -1;

    // Lines straddling the bottom of the window, including address 8191
    scan_line(366, -1);
    scan_line(367, -1);
    scan_line(368, -1);

    // Three vsync falling edges
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) step(490, 650 + i, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(490, 660 + i, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(490, 700 + i, 1'b0, 1'b1);

    @(negedge clk);
    check_out();

`ifdef SCREEN_FRAME_TICK_EN
    chk("frame_count_a", {16'd0, fc_a}, 32'(fc_m));
    chk("frame_count_b", {16'd0, fc_b}, 32'(fc_m));
    chk("frame_tick_pulses", 32'(ticks_seen), 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
